// File: rtl/lzc_serial_ctrl.sv
// lzc_serial_ctrl
//   Multi-cycle leading-zero counter for wide operands. One WIDTH-bit word is
//   accepted over a valid/ready handshake. It is then scanned one CHUNK-bit
//   segment per cycle, starting at the MSB segment. The scan stops at the
//   first non-zero segment. Each segment's count comes from a single-cycle
//   combinational LZC built on 4:1 mux primitives.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   flush      synchronous abort of any in-flight word
//   in_valid   input word valid
//   in_ready   controller can accept a word (registered)
//   in_data    operand, WIDTH bits
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   out_count  leading-zero count, 0..WIDTH
//   out_zero   operand was all zeros
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a word; in_ready high
// SCAN  | examining one chunk per cycle, MSB chunk first
// DONE  | result presented on out_count/out_zero until consumed
module lzc_serial_ctrl #(
  parameter int    WIDTH  = 64,
  parameter int    CHUNK  = 16,
  parameter string FAMILY = "Agilex"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       out_zero
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int KW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LW   = $clog2(CHUNK);
  localparam int NNIB = CHUNK / 4;

  localparam logic [KW-1:0] K_LAST   = KW'(NCH - 1);
  localparam logic [CW-1:0] CHUNK_CW = CW'(CHUNK);
  localparam logic [CW-1:0] WIDTH_CW = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             in_ready_q, out_valid_q;

  // The data register shifts left by one chunk per empty segment, so the
  // segment under test is always the top CHUNK bits.
  logic [CHUNK-1:0] chunk;
  logic             chunk_nz;
  logic [LW-1:0]    chunk_lzc;

  assign chunk    = data_q[WIDTH-1 -: CHUNK];
  assign chunk_nz = |chunk;

  // Per-nibble count: a 4:1 mux keyed by the top two bits of the nibble.
  // An all-zero nibble yields 3 but is masked by its non-zero flag.
  logic [1:0] nib_lzc [NNIB];
  logic       nib_nz  [NNIB];

  for (genvar g = 0; g < NNIB; g++) begin : g_nib
    logic [3:0] nib;
    assign nib       = chunk[CHUNK-1-4*g -: 4];
    assign nib_nz[g] = |nib;

    lzc_serial_ctrl_mux4 #(
      .W      (2),
      .FAMILY (FAMILY)
    ) u_mux (
      .sel (nib[3:2]),
      .d0  ({1'b1, ~nib[1]}),
      .d1  (2'd1),
      .d2  (2'd0),
      .d3  (2'd0),
      .y   (nib_lzc[g])
    );
  end

  // First non-zero nibble from the top decides the chunk count.
  always_comb begin
    logic found;
    found     = 1'b0;
    chunk_lzc = '0;
    for (int i = 0; i < NNIB; i++) begin
      if (!found && nib_nz[i]) begin
        chunk_lzc = LW'(4 * i) + LW'(nib_lzc[i]);
        found     = 1'b1;
      end
    end
  end

  logic accept;
  assign accept = in_valid & in_ready_q & ~flush;

  always_comb begin
    state_d = state;
    k_d     = k_q;
    acc_d   = acc_q;
    count_d = count_q;
    zero_d  = zero_q;
    data_d  = data_q;
    case (state)
      IDLE: begin
        if (accept) begin
          data_d  = in_data;
          k_d     = '0;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (flush) begin
          state_d = IDLE;
        end else if (chunk_nz) begin
          count_d = acc_q + CW'(chunk_lzc);
          zero_d  = 1'b0;
          state_d = DONE;
        end else if (k_q == K_LAST) begin
          count_d = WIDTH_CW;
          zero_d  = 1'b1;
          state_d = DONE;
        end else begin
          acc_d  = acc_q + CHUNK_CW;
          k_d    = k_q + 1'b1;
          data_d = data_q << CHUNK;
        end
      end
      DONE: begin
        // flush takes priority; a result flushed alongside out_ready is dropped
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      zero_q      <= 1'b0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      zero_q      <= zero_d;
      data_q      <= data_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = count_q;
  assign out_zero  = zero_q;

endmodule

// lzc_serial_ctrl_mux4
//   4:1 mux primitive. The Stratix 10 variant uses an AND-OR form; other
//   families use a case-based select. Both are functionally identical.
// Ports
//   sel        select
//   d0..d3     data inputs, W bits
//   y          selected data
module lzc_serial_ctrl_mux4 #(
  parameter int    W      = 2,
  parameter string FAMILY = "Agilex"
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  if (FAMILY == "Stratix 10") begin : g_andor
    assign y = ({W{sel == 2'd0}} & d0) |
               ({W{sel == 2'd1}} & d1) |
               ({W{sel == 2'd2}} & d2) |
               ({W{sel == 2'd3}} & d3);
  end else begin : g_case
    always_comb begin
      case (sel)
        2'd0:    y = d0;
        2'd1:    y = d1;
        2'd2:    y = d2;
        default: y = d3;
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_serial_ctrl.sv
// Testbench for lzc_serial_ctrl (WIDTH=64, CHUNK=16). Expected counts and
// latencies come from a bit-by-bit reference count of the operand.
module tb_lzc_serial_ctrl;

  localparam int WIDTH = 64;
  localparam int CHUNK = 16;
  localparam int NCH   = WIDTH / CHUNK;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             out_zero;
  logic [CW-1:0]    out_count;

  int n_assert = 0;
  int n_fail   = 0;

  lzc_serial_ctrl #(
    .WIDTH  (WIDTH),
    .CHUNK  (CHUNK),
    .FAMILY ("Agilex")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  function automatic int ref_lzc(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (d[i]) return n;
      n++;
    end
    return n;
  endfunction

  // Edges after the accept edge until out_valid is seen.
  function automatic int ref_lat(input logic [WIDTH-1:0] d);
    if (d == '0) return NCH;
    return ref_lzc(d) / CHUNK + 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    check($sformatf("%s ready_wait", tag), in_ready, 1);
  endtask

  task automatic run_word(input logic [WIDTH-1:0] d, input int hold, input bit noise,
                          input string tag);
    int e;
    int lz;
    lz = ref_lzc(d);
    wait_ready(tag);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    check($sformatf("%s ready_drop", tag), in_ready, 0);
    e = 0;
    while (!out_valid && e < 3 * NCH) begin
      tick();
      e++;
    end
    check($sformatf("%s latency", tag), e, ref_lat(d));
    check($sformatf("%s count", tag), out_count, lz);
    check($sformatf("%s zero", tag), out_zero, (d == '0));
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'b1;
        in_data  = ~d;
      end
      tick();
      check($sformatf("%s hold_valid", tag), out_valid, 1);
      check($sformatf("%s hold_count", tag), out_count, lz);
      check($sformatf("%s hold_ready", tag), in_ready, 0);
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("%s valid_clr", tag), out_valid, 0);
    check($sformatf("%s ready_back", tag), in_ready, 1);
  endtask

  initial begin
    bit saw_valid;

    // Reset state while rst is held
    #2;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_count", out_count, 0);
    check("rst out_zero", out_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst ready_pre", in_ready, 0);
    tick();
    check("rst ready_first_edge", in_ready, 1);

    // Directed words
    run_word(64'h8000_0000_0000_0000, 0, 1'b0, "msb");
    run_word(64'h0000_0000_0001_0000, 0, 1'b0, "mid");
    run_word(64'h0, 0, 1'b0, "allzero");
    run_word(64'h0000_0F00_0000_0000, 10, 1'b1, "stall");
    run_word(64'h1, 0, 1'b0, "b2b_lsb");

    // Flush in the second SCAN cycle
    wait_ready("flush_scan");
    in_valid = 1'b1;
    in_data  = 64'h0;
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_scan ready", in_ready, 1);
    check("flush_scan valid", out_valid, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("flush_scan no_result", saw_valid, 0);
    run_word(64'h0000_0000_0000_8000, 0, 1'b0, "after_flush");

    // flush and out_ready together in DONE: result dropped
    wait_ready("flush_done");
    in_valid = 1'b1;
    in_data  = 64'h00FF_0000_0000_0000;
    tick();
    in_valid = 1'b0;
    begin
      int e;
      e = 0;
      while (!out_valid && e < 3 * NCH) begin
        tick();
        e++;
      end
      check("flush_done reached", out_valid, 1);
      check("flush_done count", out_count, ref_lzc(64'h00FF_0000_0000_0000));
    end
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_done valid", out_valid, 0);
    check("flush_done ready", in_ready, 1);
    tick();
    check("flush_done stays_clear", out_valid, 0);

    // flush in IDLE blocks an accept
    in_valid = 1'b1;
    in_data  = 64'h8000_0000_0000_0000;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle no_accept", in_ready, 1);
    tick();
    check("flush_idle no_valid", out_valid, 0);

    // Randomized words with random consumer stalls
    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] d;
      d = {$urandom, $urandom};
      d = d >> $urandom_range(0, WIDTH);
      run_word(d, $urandom_range(0, 2), 1'(n % 2), $sformatf("rnd%0d", n));
    end

    // Async reset in the middle of SCAN
    run_word(64'h0, 0, 1'b0, "pre_reset");
    wait_ready("areset");
    in_valid = 1'b1;
    in_data  = 64'h0;
    tick();
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("areset in_ready", in_ready, 0);
    check("areset out_valid", out_valid, 0);
    check("areset out_count", out_count, 0);
    check("areset out_zero", out_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    check("areset ready_pre", in_ready, 0);
    tick();
    check("areset ready_first_edge", in_ready, 1);
    run_word(64'h0000_0000_0100_0000, 1, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
